fmlbrg_tagmem_nway: RTL and testbench

Set-associative tag store for the FML bridge cache, successor to the single-way tag memory. Holds `ways` tags per set with per-line valid and dirty bits, performs the tag compare itself and reports hit way and replacement victim one cycle after a lookup. Includes a sequential flush engine that invalidates every line. Sits between the bridge front-end (lookups) and the refill/writeback controller (updates, flush).

---
 rtl/fmlbrg_tagmem_nway.sv | 179 +++++++++++++++++
 tb/tb_fmlbrg_tagmem_nway.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fmlbrg_tagmem_nway.sv
// fmlbrg_tagmem_nway: set-associative tag store with tag compare, victim select and flush engine.
// Define FMLBRG_TAGMEM_BYPASS_EN to forward a same-cycle update into the lookup view.
module fmlbrg_tagmem_nway #(
    parameter  int depth = 2,
    parameter  int width = 2,
    parameter  int ways  = 2,
    localparam int wb    = (ways <= 2) ? 1 : 2
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             lk_stb,
    input  logic [depth-1:0] lk_set,
    input  logic [width-1:0] lk_tag,
    output logic             lk_ack,
    output logic             lk_hit,
    output logic [wb-1:0]    lk_way,
    output logic             lk_dirty,
    output logic [wb-1:0]    vic_way,
    output logic [width-1:0] vic_tag,
    output logic             vic_dirty,
    input  logic             up_we,
    input  logic [depth-1:0] up_set,
    input  logic [wb-1:0]    up_way,
    input  logic [width-1:0] up_tag,
    input  logic             up_valid,
    input  logic             up_dirty,
    input  logic             flush_req,
    output logic             ready,
    output logic             flush_done
);
    localparam int sets = 1 << depth;

    typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_DONE} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [depth-1:0] r_flush_set;

    logic [width-1:0] r_tag_mem [ways][sets];
    logic [ways-1:0]  r_valid   [sets];
    logic [ways-1:0]  r_dirty   [sets];
    logic [wb-1:0]    r_rr      [sets];

    // Lookup snapshot: everything the compare needs, captured at the lookup edge.
    logic             r_ack;
    logic [width-1:0] r_lk_tag;
    logic [ways-1:0]  r_s_valid;
    logic [ways-1:0]  r_s_dirty;
    logic [wb-1:0]    r_s_rr;
    logic [width-1:0] r_s_tag [ways];

    logic             w_lk_go;
    logic             w_up_go;
    logic [wb-1:0]    w_up_way;
    logic             w_rr_adv;
    logic [wb-1:0]    w_rr_next;
    logic [ways-1:0]  w_v_valid;
    logic [ways-1:0]  w_v_dirty;
    logic [wb-1:0]    w_v_rr;
    logic [width-1:0] w_v_tag [ways];
    logic             w_hit;
    logic [wb-1:0]    w_hit_way;
    logic             w_hit_dirty;
    logic [wb-1:0]    w_vic_way;

    assign ready      = (r_state == ST_IDLE);
    assign flush_done = (r_state == ST_DONE);
    assign w_lk_go    = lk_stb & ready;
    assign w_up_go    = up_we & ready;
    assign w_up_way   = (ways == 1) ? '0 : up_way;
    assign w_rr_adv   = up_valid && (w_up_way == r_rr[up_set]);
    assign w_rr_next  = (r_rr[up_set] == wb'(ways - 1)) ? '0 : r_rr[up_set] + 1'b1;

    // ---------------- flush FSM ----------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= ST_IDLE;
            r_flush_set <= '0;
        end else begin
            r_state     <= w_state_next;
            r_flush_set <= (r_state == ST_SWEEP) ? r_flush_set + 1'b1 : '0;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (flush_req) w_state_next = ST_SWEEP;
            ST_SWEEP: if (&r_flush_set) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // ---------------- storage ----------------
    // NOTE: the tag RAM carries no reset; valid bits alone decide whether its contents matter.
    always_ff @(posedge sys_clk) begin
        if (w_up_go) r_tag_mem[w_up_way][up_set] <= up_tag;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int s = 0; s < sets; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                r_rr[s]    <= '0;
            end
        end else if (r_state == ST_SWEEP) begin
            r_valid[r_flush_set] <= '0;
            r_dirty[r_flush_set] <= '0;
            r_rr[r_flush_set]    <= '0;
        end else if (w_up_go) begin
            r_valid[up_set][w_up_way] <= up_valid;
            r_dirty[up_set][w_up_way] <= up_dirty;
            if (w_rr_adv) r_rr[up_set] <= w_rr_next;
        end
    end

    // ---------------- lookup view ----------------
    always_comb begin
        w_v_valid = r_valid[lk_set];
        w_v_dirty = r_dirty[lk_set];
        w_v_rr    = r_rr[lk_set];
        for (int w = 0; w < ways; w++) w_v_tag[w] = r_tag_mem[w][lk_set];
`ifdef FMLBRG_TAGMEM_BYPASS_EN
        if (w_up_go && (up_set == lk_set)) begin
            w_v_valid[w_up_way] = up_valid;
            w_v_dirty[w_up_way] = up_dirty;
            w_v_tag[w_up_way]   = up_tag;
            if (w_rr_adv) w_v_rr = w_rr_next;
        end
`endif
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_ack     <= 1'b0;
            r_lk_tag  <= '0;
            r_s_valid <= '0;
            r_s_dirty <= '0;
            r_s_rr    <= '0;
            for (int w = 0; w < ways; w++) r_s_tag[w] <= '0;
        end else begin
            r_ack <= w_lk_go;
            if (w_lk_go) begin
                r_lk_tag  <= lk_tag;
                r_s_valid <= w_v_valid;
                r_s_dirty <= w_v_dirty;
                r_s_rr    <= w_v_rr;
                for (int w = 0; w < ways; w++) r_s_tag[w] <= w_v_tag[w];
            end
        end
    end

    // Descending scan so the lowest matching / lowest invalid way wins.
    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_hit_dirty = 1'b0;
        w_vic_way   = r_s_rr;
        for (int w = ways - 1; w >= 0; w--) begin
            if (r_s_valid[w] && (r_s_tag[w] == r_lk_tag)) begin
                w_hit       = 1'b1;
                w_hit_way   = wb'(w);
                w_hit_dirty = r_s_dirty[w];
            end
            if (!r_s_valid[w]) w_vic_way = wb'(w);
        end
    end

    assign lk_ack    = r_ack;
    assign lk_hit    = w_hit;
    assign lk_way    = w_hit_way;
    assign lk_dirty  = w_hit_dirty;
    assign vic_way   = w_vic_way;
    assign vic_tag   = r_s_tag[w_vic_way];
    assign vic_dirty = r_s_valid[w_vic_way] & r_s_dirty[w_vic_way];
endmodule

// File: tb/tb_fmlbrg_tagmem_nway.sv
// tb_fmlbrg_tagmem_nway: directed and random checks of the n-way tag store against an array model.
module tb_fmlbrg_tagmem_nway;
    localparam int DEPTH = 2;
    localparam int WIDTH = 2;
    localparam int WAYS  = 2;
    localparam int WB    = 1;
    localparam int SETS  = 1 << DEPTH;

    logic             sys_clk = 1'b0;
    logic             sys_rst_n = 1'b0;
    logic             lk_stb = 1'b0;
    logic [DEPTH-1:0] lk_set = '0;
    logic [WIDTH-1:0] lk_tag = '0;
    logic             lk_ack, lk_hit, lk_dirty, vic_dirty, ready, flush_done;
    logic [WB-1:0]    lk_way, vic_way;
    logic [WIDTH-1:0] vic_tag;
    logic             up_we = 1'b0;
    logic [DEPTH-1:0] up_set = '0;
    logic [WB-1:0]    up_way = '0;
    logic [WIDTH-1:0] up_tag = '0;
    logic             up_valid = 1'b0, up_dirty = 1'b0, flush_req = 1'b0;

    fmlbrg_tagmem_nway #(.depth(DEPTH), .width(WIDTH), .ways(WAYS)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .lk_stb(lk_stb), .lk_set(lk_set), .lk_tag(lk_tag),
        .lk_ack(lk_ack), .lk_hit(lk_hit), .lk_way(lk_way), .lk_dirty(lk_dirty),
        .vic_way(vic_way), .vic_tag(vic_tag), .vic_dirty(vic_dirty),
        .up_we(up_we), .up_set(up_set), .up_way(up_way), .up_tag(up_tag),
        .up_valid(up_valid), .up_dirty(up_dirty),
        .flush_req(flush_req), .ready(ready), .flush_done(flush_done)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference model: plain arrays of lines plus a flush countdown.
    int  m_tag   [SETS][WAYS];
    bit  m_known [SETS][WAYS];
    bit  m_valid [SETS][WAYS];
    bit  m_dirty [SETS][WAYS];
    int  m_rr    [SETS];
    int  m_left;

    bit  e_ack, e_hit, e_dirty, e_vd, e_vtag_known;
    int  e_way, e_vway, e_vtag;

    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic check_all();
        check("ready", 32'(ready), 32'(m_left == 0));
        check("flush_done", 32'(flush_done), 32'(m_left == 1));
        check("lk_ack", 32'(lk_ack), 32'(e_ack));
        check("lk_hit", 32'(lk_hit), 32'(e_hit));
        check("lk_way", 32'(lk_way), 32'(e_way));
        check("lk_dirty", 32'(lk_dirty), 32'(e_dirty));
        check("vic_way", 32'(vic_way), 32'(e_vway));
        check("vic_dirty", 32'(vic_dirty), 32'(e_vd));
        if (e_vtag_known) check("vic_tag", 32'(vic_tag), 32'(e_vtag));
    endtask

    task automatic model_clear_lines();
        for (int s = 0; s < SETS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        model_clear_lines();
        m_left = 0;
        e_ack = 0; e_hit = 0; e_way = 0; e_dirty = 0;
        e_vway = 0; e_vd = 0; e_vtag = 0; e_vtag_known = 1;
    endtask

    task automatic model_lookup(input int s, input int t);
        bit found;
        e_ack = 1; e_hit = 0; e_way = 0; e_dirty = 0;
        for (int w = 0; w < WAYS; w++)
            if (!e_hit && m_valid[s][w] && m_tag[s][w] == t) begin
                e_hit = 1; e_way = w; e_dirty = m_dirty[s][w];
            end
        found  = 0;
        e_vway = m_rr[s];
        for (int w = 0; w < WAYS; w++)
            if (!found && !m_valid[s][w]) begin
                found = 1; e_vway = w;
            end
        e_vtag       = m_tag[s][e_vway];
        e_vtag_known = m_known[s][e_vway];
        e_vd         = m_valid[s][e_vway] && m_dirty[s][e_vway];
    endtask

    task automatic model_update(input int s, input int w, input int t, input bit v, input bit d);
        m_tag[s][w]   = t;
        m_known[s][w] = 1;
        m_valid[s][w] = v;
        m_dirty[s][w] = d;
        if (v && w == m_rr[s]) m_rr[s] = (m_rr[s] + 1) % WAYS;
    endtask

    // One clock: drive, predict, step past the edge, compare.
    task automatic cycle(input bit lk, input int ls, input int lt,
                         input bit up, input int us, input int uw, input int ut,
                         input bit uv, input bit ud, input bit fl);
        bit fwd;
        lk_stb = lk; lk_set = ls[DEPTH-1:0]; lk_tag = lt[WIDTH-1:0];
        up_we = up; up_set = us[DEPTH-1:0]; up_way = uw[WB-1:0]; up_tag = ut[WIDTH-1:0];
        up_valid = uv; up_dirty = ud; flush_req = fl;
        e_ack = 0;
        if (m_left == 0) begin
            fwd = 0;
`ifdef FMLBRG_TAGMEM_BYPASS_EN
            fwd = lk && up && (ls == us);
`endif
            if (lk && !fwd) model_lookup(ls, lt);
            if (up) model_update(us, uw, ut, uv, ud);
            if (lk && fwd) model_lookup(ls, lt);
            if (fl) begin
                model_clear_lines();
                m_left = SETS + 1;
            end
        end else begin
            m_left--;
        end
        @(posedge sys_clk);
        #1;
        lk_stb = 0; up_we = 0; flush_req = 0;
        check_all();
    endtask

    task automatic lookup(input int s, input int t);
        cycle(1, s, t, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic update(input int s, input int w, input int t, input bit v, input bit d);
        cycle(0, 0, 0, 1, s, w, t, v, d, 0);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_tag[s][w] = 0;
                m_known[s][w] = 0;
            end
        model_reset();
        repeat (2) @(posedge sys_clk);
        #1;
        check_all();
        sys_rst_n = 1'b1;
        idle();

        // Cold lookup misses, victim is way 0.
        lookup(1, 3);
        // Written line hits on the next cycle.
        update(1, 0, 3, 1, 1);
        lookup(1, 3);
        lookup(1, 2);

        // Fill set 2 repeatedly: victim rotates with the round-robin pointer.
        update(2, 0, 1, 1, 0);
        lookup(2, 1);
        update(2, 1, 2, 1, 1);
        lookup(2, 0);
        update(2, 0, 3, 1, 1);
        lookup(2, 3);
        update(2, 1, 0, 1, 0);
        lookup(2, 2);
        // Same tag in both ways: lowest way reported.
        update(2, 1, 3, 1, 0);
        lookup(2, 3);

        // Same-cycle update and lookup to set 3.
        cycle(1, 3, 2, 1, 3, 1, 2, 1, 0, 0);
        lookup(3, 2);

        // Flush with a lookup in the request cycle; traffic during the sweep is ignored.
        cycle(1, 1, 3, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < SETS + 1; i++) cycle(1, i % SETS, 3, 1, 0, 0, 1, 1, 1, 1);
        for (int s = 0; s < SETS; s++) lookup(s, 3);
        lookup(2, 0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 1) == 1, $urandom_range(0, SETS - 1), $urandom_range(0, 3),
                  $urandom_range(0, 2) == 0, $urandom_range(0, SETS - 1), $urandom_range(0, WAYS - 1),
                  $urandom_range(0, 3), $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 59) == 0);
        end
        while (m_left != 0) idle();

        // Reset during the sweep.
        for (int s = 0; s < SETS; s++) update(s, 0, s, 1, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle();
        sys_rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        #2;
        sys_rst_n = 1'b1;
        for (int s = 0; s < SETS; s++) lookup(s, s);
        update(0, 1, 2, 1, 0);
        lookup(0, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
